// File: rtl/cnn_pkg.sv
// cnn_pkg -- shared definitions for the CNN datapath blocks.
//   DW       : feature / weight width (signed Q-format)
//   FRAC     : default number of fraction bits
//   ACC_W    : accumulator width (16 products of 32 bits need 36 bits)
//   SAT_MAX/SAT_MIN : clamp limits for a DW-bit signed result
//   fc_state_t : fully-connected layer controller states
//   sat_shift  : arithmetic shift right + clamp to DW bits
package cnn_pkg;

    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 36;
    localparam int PW    = 2 * DW;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FINISH  = 2'd2
    } fc_state_t;

    function automatic logic signed [DW-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc,
        input int                      frac
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> frac;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return shifted[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/fc_mac.sv
// fc_mac -- multiply-accumulate and output stage of the FC layer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : accumulate this cycle's product
//   i_first    : product is the first of a neuron (load instead of add)
//   i_feat     : signed feature operand
//   i_wgt      : signed weight operand
//   i_emit     : accumulator holds a finished neuron; publish it
//   i_idx      : neuron index published with the result
//   o_valid    : one-cycle result strobe
//   o_data     : shifted and saturated accumulator (held between strobes)
//   o_idx      : neuron index of o_data (held between strobes)
module fc_mac
    import cnn_pkg::*;
#(
    parameter int FRAC  = cnn_pkg::FRAC,
    parameter int IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_first,
    input  logic signed [DW-1:0]    i_feat,
    input  logic signed [DW-1:0]    i_wgt,
    input  logic                    i_emit,
    input  logic [IDX_W-1:0]        i_idx,
    output logic                    o_valid,
    output logic signed [DW-1:0]    o_data,
    output logic [IDX_W-1:0]        o_idx
);

    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_valid;
    logic signed [DW-1:0]    r_data;
    logic [IDX_W-1:0]        r_idx;

    assign w_prod     = i_feat * i_wgt;
    assign w_prod_ext = ACC_W'(w_prod);

    // Loading on the first product clears the previous neuron's sum
    // without spending a cycle on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_first ? w_prod_ext : (r_acc + w_prod_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_valid <= i_emit;
            if (i_emit) begin
                r_data <= sat_shift(r_acc, FRAC);
                r_idx  <= i_idx;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_idx   = r_idx;

endmodule

// File: rtl/fc_layer.sv
// fc_layer -- fully-connected layer over one pooled feature frame.
// Features are captured into a buffer while in FILL; on in_done every
// neuron o is computed as sum_i feature[i]*weight[o*N_IN+i] from an
// external ROM with one-cycle read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid/in_data/in_addr : pooled feature write strobe, value, index
//   in_done    : frame complete, start computing
//   w_addr/w_data : weight ROM address out, weight data in (1 cycle later)
//   out_valid/out_data/out_idx : per-neuron result strobe, value, index
//   busy       : high while computing
//   done       : one-cycle pulse after the last neuron
module fc_layer
    import cnn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 4,
    parameter int FRAC  = cnn_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [15:0]   in_data,
    input  logic [5:0]           in_addr,
    input  logic                 in_done,
    output logic [5:0]           w_addr,
    input  logic signed [15:0]   w_data,
    output logic                 out_valid,
    output logic signed [15:0]   out_data,
    output logic [1:0]           out_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(N_IN);
    localparam int CW = $clog2(N_IN + 1);
    localparam int OW = $clog2(N_OUT) + 1;
    localparam int XW = 2;

    fc_state_t             r_state;
    fc_state_t             w_state_next;
    logic [CW-1:0]         r_i;
    logic [OW-1:0]         r_o;
    logic [5:0]            r_w_addr;
    logic                  w_issue;
    logic                  w_fetch;

    logic                  r_d1_valid;
    logic                  r_d1_first;
    logic                  r_d1_last;
    logic [IW-1:0]         r_d1_i;
    logic [XW-1:0]         r_d1_o;
    logic                  r_emit;
    logic [XW-1:0]         r_emit_o;
    logic                  r_done;
    logic                  w_last_emit;

    logic signed [DW-1:0]  r_buf [N_IN];
    logic signed [DW-1:0]  w_feat;

    // r_o runs one past the last neuron so issuing stops while the
    // pipeline drains the final result.
    assign w_issue     = (r_state == S_COMPUTE) && (r_o < OW'(N_OUT));
    assign w_fetch     = w_issue && (r_i != CW'(N_IN));
    assign w_last_emit = r_emit && (r_emit_o == XW'(N_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:    if (in_done) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last_emit) w_state_next = S_FINISH;
            S_FINISH:  w_state_next = S_FILL;
            default:   w_state_next = S_FILL;
        endcase
    end

    // Address sequencer: N_IN fetch cycles then one idle cycle per neuron.
    // The address already points at the next neuron during the idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i      <= '0;
            r_o      <= '0;
            r_w_addr <= '0;
        end else if ((r_state == S_FILL) && in_done) begin
            r_i      <= '0;
            r_o      <= '0;
            r_w_addr <= '0;
        end else if (w_issue) begin
            if (w_fetch) begin
                r_i      <= r_i + CW'(1);
                r_w_addr <= r_w_addr + 6'd1;
            end else begin
                r_i <= '0;
                r_o <= r_o + OW'(1);
            end
        end
    end

    // Tags travel with the ROM latency so the feature read lines up
    // with the weight arriving on w_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1_valid <= 1'b0;
            r_d1_first <= 1'b0;
            r_d1_last  <= 1'b0;
            r_d1_i     <= '0;
            r_d1_o     <= '0;
            r_emit     <= 1'b0;
            r_emit_o   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_d1_valid <= w_fetch;
            r_d1_first <= (r_i == CW'(0));
            r_d1_last  <= (r_i == CW'(N_IN - 1));
            r_d1_i     <= r_i[IW-1:0];
            r_d1_o     <= r_o[XW-1:0];
            r_emit     <= r_d1_valid && r_d1_last;
            r_emit_o   <= r_d1_o;
            r_done     <= (r_state == S_FINISH);
        end
    end

    // Feature buffer: cleared at reset and on the way back to FILL, so
    // entries not written in a frame contribute zero.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_buf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_buf[gi] <= '0;
                end else if (r_state == S_FINISH) begin
                    r_buf[gi] <= '0;
                end else if ((r_state == S_FILL) && in_valid && (in_addr == 6'(gi))) begin
                    r_buf[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign w_feat = r_buf[r_d1_i];

    fc_mac #(
        .FRAC  (FRAC),
        .IDX_W (XW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_d1_valid),
        .i_first (r_d1_first),
        .i_feat  (w_feat),
        .i_wgt   (w_data),
        .i_emit  (r_emit),
        .i_idx   (r_emit_o),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_idx   (out_idx)
    );

    assign w_addr = r_w_addr;
    assign busy   = (r_state == S_COMPUTE);
    assign done   = r_done;

endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer -- directed, table-driven bench for fc_layer with a
// one-cycle-latency weight ROM model.
module tb_fc_layer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic [5:0]         in_addr;
    logic               in_done;
    logic [5:0]         w_addr;
    logic signed [15:0] w_data = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic [1:0]         out_idx;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    fc_layer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_done   (in_done),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    logic signed [15:0] rom [64];
    always @(posedge clk) w_data <= rom[w_addr];

    typedef struct {
        logic signed [15:0]      feat;
        bit                      full;
        logic [3:0][15:0]        w;
        logic [3:0][15:0]        exp;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int feat, input bit full,
                                input int w0, input int w1, input int w2, input int w3,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.feat   = 16'(feat);
        v.full   = full;
        v.w[0]   = 16'(w0);
        v.w[1]   = 16'(w1);
        v.w[2]   = 16'(w2);
        v.w[3]   = 16'(w3);
        v.exp[0] = 16'(e0);
        v.exp[1] = 16'(e1);
        v.exp[2] = 16'(e2);
        v.exp[3] = 16'(e3);
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input vec_t v);
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 16; i++)
                rom[o*16+i] = $signed(v.w[o]);
    endtask

    // Writes the frame; the final feature write coincides with in_done.
    task automatic load_frame(input vec_t v);
        if (v.full) begin
            for (int i = 0; i < 16; i++) begin
                in_valid = 1'b1;
                in_addr  = 6'(i);
                in_data  = v.feat;
                in_done  = (i == 15);
                tick();
            end
        end else begin
            in_valid = 1'b1; in_addr = 6'd16; in_data = 16'sd1000; in_done = 1'b0;
            tick();
            in_valid = 1'b1; in_addr = 6'd0;  in_data = v.feat;    in_done = 1'b1;
            tick();
        end
        in_valid = 1'b0; in_addr = '0; in_data = '0; in_done = 1'b0;
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int   bad_v = -1;
        int   bad_b = -1;
        int   bad_d = -1;
        logic exp_v, exp_b, exp_d;
        load_rom(v);
        load_frame(v);
        // k counts edges since the one that sampled in_done
        for (int k = 0; k <= 76; k++) begin
            exp_v = (k >= 18) && (k <= 69) && (((k - 18) % 17) == 0);
            exp_b = (k <= 68);
            exp_d = (k == 70);
            if (out_valid !== exp_v && bad_v < 0) bad_v = k;
            if (busy !== exp_b && bad_b < 0) bad_b = k;
            if (done !== exp_d && bad_d < 0) bad_d = k;
            for (int o = 0; o < 4; o++) begin
                if (k == 18 + 17*o) begin
                    check($sformatf("v%0d_data_n%0d", id, o), longint'($signed(out_data)), longint'($signed(v.exp[o])));
                    check($sformatf("v%0d_idx_n%0d", id, o), longint'(out_idx), longint'(o));
                end
            end
            if (k == 30)
                check($sformatf("v%0d_hold", id), longint'($signed(out_data)), longint'($signed(v.exp[0])));
            // stray strobes while computing / finishing must be ignored
            if (k == 4 || k == 69) begin
                in_valid = 1'b1; in_addr = (k == 4) ? 6'd0 : 6'd1; in_data = 16'sd9999; in_done = 1'b1;
            end else begin
                in_valid = 1'b0; in_addr = '0; in_data = '0; in_done = 1'b0;
            end
            tick();
        end
        check($sformatf("v%0d_valid_timing_first_bad_edge", id), bad_v, -1);
        check($sformatf("v%0d_busy_window_first_bad_edge", id), bad_b, -1);
        check($sformatf("v%0d_done_timing_first_bad_edge", id), bad_d, -1);
        $display("vector %0d: feat=%0d full=%0d out={%0d,%0d,%0d,%0d}", id, v.feat, v.full,
                 $signed(v.exp[0]), $signed(v.exp[1]), $signed(v.exp[2]), $signed(v.exp[3]));
    endtask

    initial begin
        int strobes;
        vecs[0] = mk(256,   1, 256,    256,    256,    256,    4096,   4096,   4096,   4096);
        vecs[1] = mk(256,   1, 256,    -256,   256,    256,    4096,   -4096,  4096,   4096);
        vecs[2] = mk(32767, 1, 32767,  32767,  32767,  32767,  32767,  32767,  32767,  32767);
        vecs[3] = mk(32767, 1, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        vecs[4] = mk(256,   0, 256,    256,    256,    256,    256,    256,    256,    256);
        vecs[5] = mk(512,   1, 128,    -128,   0,      1024,   4096,   -4096,  0,      32767);
        vecs[6] = mk(1,     1, -1,     -1,     -1,     -1,     -1,     -1,     -1,     -1);

        for (int i = 0; i < 64; i++) rom[i] = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; in_done = 1'b0;
        tick(); tick(); tick();
        check("reset_outputs", longint'({out_valid, out_data, out_idx, busy, done, w_addr}), 0);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 7; n++) run_frame(n, vecs[n]);

        // Abort a frame with reset 5 edges after in_done
        load_rom(vecs[0]);
        load_frame(vecs[0]);
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", longint'({out_valid, out_data, out_idx, busy, done, w_addr}), 0);
        tick(); tick();
        rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (out_valid || done || busy) strobes++;
        end
        check("midreset_no_activity", strobes, 0);
        $display("vector reset: abort mid-compute, activity cycles=%0d", strobes);

        // Buffer must have been cleared by reset; then a normal frame.
        run_frame(7, vecs[4]);
        run_frame(8, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer.md
FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 SHALL provide parameter N_IN, default 16, meaning number of pooled features per frame (4x4 pooled map).
REQ-002 SHALL provide parameter N_OUT, default 4, meaning number of output neurons.
REQ-003 SHALL provide parameter FRAC, default 8, meaning Q-format fraction bits of features and weights.
REQ-004 SHALL provide ports, one per line, as follows:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  pooled feature strobe (driven by pooling reg_sig).
- in_data  input  16  signed pooled feature (pooling result).
- in_addr  input  6  feature index (pooling addr).
- in_done  input  1  frame-complete pulse (pooling done_pl).
- w_addr  output  6  weight ROM address, o*N_IN+i.
- w_data  input  16  signed weight; valid exactly 1 cycle after w_addr.
- out_valid  output  1  one-cycle result strobe.
- out_data  output  16  signed saturated neuron output.
- out_idx  output  2  neuron index of out_data.
- busy  output  1  high in COMPUTE.
- done  output  1  one-cycle pulse after last neuron.

Function
REQ-005 SHALL implement states FILL, COMPUTE, FINISH; reset state FILL.
REQ-006 In FILL, in_valid with in_addr<N_IN SHALL write in_data to feature buffer[in_addr]; in_addr>=N_IN SHALL be ignored.
REQ-007 FILL SHALL move to COMPUTE on the edge sampling in_done=1; a simultaneous in_valid write SHALL complete before transition.
REQ-008 Buffer entries not written in a frame SHALL read as 0 (buffer cleared on entry to FILL and at reset).
REQ-009 In COMPUTE, w_addr SHALL step through o*N_IN+i, i=0..N_IN-1, per neuron o=0..N_OUT-1, one address per cycle, with one idle cycle between neurons for ROM latency.
REQ-010 Product SHALL be 16x16 signed -> 32 bits; accumulator SHALL be 36-bit signed, cleared at start of each neuron; no overflow possible for N_IN<=16.
REQ-011 out_data SHALL equal accumulator arithmetically shifted right FRAC, clamped to [-32768, 32767].
REQ-012 First out_valid SHALL assert N_IN+2 cycles after the edge sampling in_done; each subsequent one N_IN+1 cycles later; out_idx=o.
REQ-013 in_valid and in_done during COMPUTE or FINISH SHALL be ignored.
REQ-014 After the last out_valid, FINISH SHALL pulse done for one cycle, then return to FILL.
REQ-015 busy SHALL be 1 exactly while state is COMPUTE.
REQ-016 out_data and out_idx SHALL hold last value between strobes.

Reset
REQ-017 rst_n low SHALL, asynchronously, force state FILL, buffer 0, accumulator 0, w_addr 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0.
REQ-018 Reset mid-COMPUTE SHALL abort the frame with no further out_valid or done; operation resumes in FILL after release.

Structure
REQ-019 Shared package cnn_pkg SHALL hold DW=16, FRAC, ACC_W=36, SAT_MAX/SAT_MIN, and the fc state type.
REQ-020 Multiply, accumulate and shift-saturate SHALL live in sub-module fc_mac; control and buffer in fc_layer.

Verification
REQ-021 All 16 features 256, ROM all 256, in_done -> four out_valid, out_data=4096, out_idx 0..3, then done.
REQ-022 Features 256, ROM neuron 1 all -256 -> out_idx=1 gives -4096; others 4096.
REQ-023 Features 32767, weights 32767 -> out_data=32767 (saturated); weights -32768 -> -32768.
REQ-024 Only addr 0 written (256), plus addr 16 written 1000, weights 256 -> out_data=256 for every neuron (addr 16 ignored, rest zero).
REQ-025 rst_n low 5 cycles after in_done -> all outputs 0 immediately, no done; next full frame yields REQ-021 values.
REQ-026 Check first out_valid at in_done edge +18 cycles, spacing 17, done one cycle after last strobe, busy window matching.
